// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared constants for the LDM/STM block-transfer sequencer: addressing modes,
// architectural register indices and FSM state encodings.
package ldm_stm_sequencer_pkg;

  // Addressing modes encoded as {P, U}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/ldm_stm_sequencer_prio_enc16.sv
// 16-input priority encoder (prio_enc16): index of the lowest set bit plus an
// any-bit-set flag. Used to pick the next register of a block transfer.
module ldm_stm_sequencer_prio_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        any
);

  // Scanning downwards lets the lowest set bit win the last assignment
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list in ascending order, moving one word
// per memory handshake between the register bank and memory.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre_idx,
  input  logic              up,
  input  logic              wback,
  input  logic [3:0]        base_sel,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_list,
  output logic [3:0]        rb_read_sel,
  input  logic [DATA_W-1:0] rb_read_data,
  output logic              rb_write_en,
  output logic [3:0]        rb_write_sel,
  output logic [DATA_W-1:0] rb_write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W-2){1'b1}}, 2'b00};
  localparam logic [DATA_W-1:0] WORD       = DATA_W'(4);

  logic [2:0]        state;
  logic [NREGS-1:0]  list_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] base_r;
  logic [3:0]        base_sel_r;
  logic              is_load_r;
  logic              pre_r;
  logic              up_r;
  logic              wb_r;

  logic [3:0]        cur_idx;
  logic              list_any;
  logic [NREGS-1:0]  cur_mask;
  logic              last_reg;
  logic [4:0]        n_regs;
  logic [DATA_W-1:0] four_n;
  logic [DATA_W-1:0] start_addr;
  logic [DATA_W-1:0] new_base;

  ldm_stm_sequencer_prio_enc16 u_prio (
    .vec (list_r),
    .idx (cur_idx),
    .any (list_any)
  );

  assign cur_mask = NREGS'(1) << cur_idx;
  assign last_reg = ((list_r & ~cur_mask) == '0);

  always_comb begin
    n_regs = '0;
    for (int i = 0; i < NREGS; i++) begin
      n_regs = n_regs + 5'(list_r[i]);
    end
  end

  // Decrementing modes still transfer upwards, starting from the lowest word of the block
  always_comb begin
    four_n = DATA_W'(n_regs) << 2;
    case ({pre_r, up_r})
      MODE_IA: start_addr = base_r;
      MODE_IB: start_addr = base_r + WORD;
      MODE_DA: start_addr = base_r - four_n + WORD;
      default: start_addr = base_r - four_n;
    endcase
    start_addr = start_addr & ALIGN_MASK;
    new_base   = (up_r ? (base_r + four_n) : (base_r - four_n)) & ALIGN_MASK;
  end

  // base_r holds the sampled base until SETUP, then the written-back base
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      list_r     <= '0;
      addr_r     <= '0;
      base_r     <= '0;
      base_sel_r <= '0;
      is_load_r  <= 1'b0;
      pre_r      <= 1'b0;
      up_r       <= 1'b0;
      wb_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            list_r     <= reg_list;
            base_r     <= base_addr;
            base_sel_r <= base_sel;
            is_load_r  <= is_load;
            pre_r      <= pre_idx;
            up_r       <= up;
            wb_r       <= wback;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          addr_r <= start_addr;
          base_r <= new_base;
          wb_r   <= wb_r && !(is_load_r && list_r[base_sel_r]);
          state  <= list_any ? S_XFER : S_DONE;
        end
        S_XFER: begin
          if (mem_ack) begin
            list_r <= list_r & ~cur_mask;
            addr_r <= addr_r + WORD;
            if (last_reg) begin
              state <= wb_r ? S_WB : S_DONE;
            end
          end
        end
        S_WB:    state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state; STM data and LDM writes pass through combinationally
  always_comb begin
    rb_read_sel   = '0;
    rb_write_en   = 1'b0;
    rb_write_sel  = '0;
    rb_write_data = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_SETUP: busy = 1'b1;
      S_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_r;
        mem_we   = !is_load_r;
        if (!is_load_r) begin
          rb_read_sel = cur_idx;
          mem_wdata   = rb_read_data;
        end else if (mem_ack) begin
          rb_write_en   = 1'b1;
          rb_write_sel  = cur_idx;
          rb_write_data = mem_rdata;
        end
      end
      S_WB: begin
        busy          = 1'b1;
        rb_write_en   = 1'b1;
        rb_write_sel  = base_sel_r;
        rb_write_data = base_r;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: command table plus scoreboard queues
// of expected memory transactions and register-bank writes.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        pre_idx;
  logic        up;
  logic        wback;
  logic [3:0]  base_sel;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic [3:0]  rb_read_sel;
  logic [31:0] rb_read_data;
  logic        rb_write_en;
  logic [3:0]  rb_write_sel;
  logic [31:0] rb_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;

  logic [31:0] bank [16];
  logic        init_bank;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_load;
    logic        pre;
    logic        up;
    logic        wback;
    logic [3:0]  base_sel;
    logic [31:0] base;
    logic [15:0] list;
    int          wait_cyc;
    logic [31:0] load_base;
    int          restart_cyc;
    logic        stray_ack;
    logic [31:0] exp_first;
    logic        exp_wb;
    logic [31:0] exp_new_base;
    int          exp_done;
    int          exp_mem;
    int          exp_wr;
  } cmd_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] data;
  } wr_txn_t;

  mem_txn_t mem_q [$];
  wr_txn_t  wr_q  [$];
  cmd_t     tbl   [7];

  ldm_stm_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .is_load       (is_load),
    .pre_idx       (pre_idx),
    .up            (up),
    .wback         (wback),
    .base_sel      (base_sel),
    .base_addr     (base_addr),
    .reg_list      (reg_list),
    .rb_read_sel   (rb_read_sel),
    .rb_read_data  (rb_read_data),
    .rb_write_en   (rb_write_en),
    .rb_write_sel  (rb_write_sel),
    .rb_write_data (rb_write_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Register bank model: every register starts as 0xD000_0000 + index
  always @(posedge clk) begin
    if (init_bank) begin
      for (int i = 0; i < 16; i++) bank[i] <= 32'hD000_0000 + 32'(i);
    end else if (rb_write_en) begin
      bank[rb_write_sel] <= rb_write_data;
    end
  end

  assign rb_read_data = bank[rb_read_sel];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    init_bank = 1'b1;
    start     = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    init_bank = 1'b0;
  endtask

  task automatic apply_stimulus(input cmd_t c, input bit with_reset);
    int          done_cyc;
    int          n_mem;
    int          n_wr;
    int          busy_cnt;
    int          wcnt;
    int          ld_idx;
    int          k;
    logic [31:0] a;
    mem_txn_t    mt;
    wr_txn_t     wt;

    if (with_reset) do_reset();
    mem_q.delete();
    wr_q.delete();
    a = c.exp_first;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (c.list[i]) begin
        if (c.is_load) begin
          mem_q.push_back('{1'b0, a, 32'h0});
          wr_q.push_back('{4'(i), c.load_base + 32'(k)});
        end else begin
          mem_q.push_back('{1'b1, a, 32'hD000_0000 + 32'(i)});
        end
        a = a + 32'd4;
        k++;
      end
    end
    if (c.exp_wb) wr_q.push_back('{c.base_sel, c.exp_new_base});

    @(negedge clk);
    start     = 1'b1;
    is_load   = c.is_load;
    pre_idx   = c.pre;
    up        = c.up;
    wback     = c.wback;
    base_sel  = c.base_sel;
    base_addr = c.base;
    reg_list  = c.list;
    mem_ack   = 1'b0;
    done_cyc  = -1;
    n_mem     = 0;
    n_wr      = 0;
    busy_cnt  = 0;
    wcnt      = 0;
    ld_idx    = 0;

    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (c.restart_cyc != 0 && cyc == c.restart_cyc) begin
        start    = 1'b1;
        reg_list = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      if (mem_req) begin
        if (wcnt == c.wait_cyc) begin
          mem_ack   = 1'b1;
          mem_rdata = c.load_base + 32'(ld_idx);
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = (c.stray_ack && cyc == 1);
        wcnt    = 0;
      end
      #1;
      if (busy) busy_cnt++;
      if (mem_req && mem_ack) begin
        n_mem++;
        wcnt = 0;
        ld_idx++;
        if (mem_q.size() == 0) begin
          check_output("unexpected_mem_txn", mem_addr, 32'hFFFF_FFFF);
        end else begin
          mt = mem_q.pop_front();
          check_output("mem_we", 32'(mem_we), 32'(mt.we));
          check_output("mem_addr", mem_addr, mt.addr);
          if (mt.we) check_output("mem_wdata", mem_wdata, mt.wdata);
        end
      end
      if (rb_write_en) begin
        n_wr++;
        if (wr_q.size() == 0) begin
          check_output("unexpected_rb_write", 32'(rb_write_sel), 32'hFFFF_FFFF);
        end else begin
          wt = wr_q.pop_front();
          check_output("rb_write_sel", 32'(rb_write_sel), 32'(wt.sel));
          check_output("rb_write_data", rb_write_data, wt.data);
        end
      end
      if (done) begin
        done_cyc = cyc;
        check_output("busy_at_done", 32'(busy), 32'd0);
        break;
      end
    end
    mem_ack = 1'b0;

    check_output("done_cycle", done_cyc, c.exp_done);
    check_output("mem_txn_count", n_mem, c.exp_mem);
    check_output("rb_write_count", n_wr, c.exp_wr);
    check_output("busy_cycles", busy_cnt, c.exp_done - 1);
    check_output("mem_queue_left", mem_q.size(), 32'd0);
    check_output("wr_queue_left", wr_q.size(), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    init_bank = 1'b1;
    start     = 1'b0;
    is_load   = 1'b0;
    pre_idx   = 1'b0;
    up        = 1'b0;
    wback     = 1'b0;
    base_sel  = 4'd0;
    base_addr = 32'h0;
    reg_list  = 16'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    //              ld    P     U     W     bsel   base           list      wt lbase          rs stray  first          wb    newbase       dn mem wr
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0000_0100, 16'h000B, 0, 32'h0,         0, 1'b0, 32'h0000_0100, 1'b0, 32'h0,         5,  3, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_0200, 16'h00F0, 2, 32'hA0,        4, 1'b0, 32'h0000_01F0, 1'b1, 32'h0000_01F0, 15, 4, 5};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_0300, 16'h0004, 0, 32'hCAFE_0000, 0, 1'b0, 32'h0000_0300, 1'b0, 32'h0,         3,  1, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  32'h0000_0400, 16'h0000, 0, 32'h0,         0, 1'b0, 32'h0,         1'b0, 32'h0,         2,  0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  32'hFFFF_FFFC, 16'h8001, 1, 32'h55,        0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         6,  2, 2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  32'h0000_1000, 16'h0018, 0, 32'h0,         0, 1'b0, 32'h0000_0FFC, 1'b1, 32'h0000_0FF8, 5,  2, 1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_0040, 16'h0006, 0, 32'h77,        0, 1'b0, 32'h0000_003C, 1'b1, 32'h0000_0038, 5,  2, 3};

    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("reset_mem_req", 32'(mem_req), 32'd0);
    check_output("reset_mem_we", 32'(mem_we), 32'd0);
    check_output("reset_mem_addr", mem_addr, 32'd0);
    check_output("reset_mem_wdata", mem_wdata, 32'd0);
    check_output("reset_rb_write_en", 32'(rb_write_en), 32'd0);
    check_output("reset_rb_write_sel", 32'(rb_write_sel), 32'd0);
    check_output("reset_rb_write_data", rb_write_data, 32'd0);
    check_output("reset_rb_read_sel", 32'(rb_read_sel), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);

    for (int t = 0; t < 7; t++) begin
      $display("[TB] command %0d list=%h base=%h", t, tbl[t].list, tbl[t].base);
      apply_stimulus(tbl[t], 1'b1);
    end

    // Reset in the middle of an STM, right after the first word has been acked
    $display("[TB] reset mid-transfer");
    do_reset();
    @(negedge clk);
    start     = 1'b1;
    is_load   = 1'b0;
    pre_idx   = 1'b0;
    up        = 1'b1;
    wback     = 1'b1;
    base_sel  = 4'd9;
    base_addr = 32'h0000_0500;
    reg_list  = 16'h000F;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check_output("mid_first_req", 32'(mem_req), 32'd1);
    check_output("mid_first_addr", mem_addr, 32'h0000_0500);
    check_output("mid_first_wdata", mem_wdata, 32'hD000_0000);
    @(negedge clk);
    mem_ack = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    #1;
    check_output("mid_reset_mem_req", 32'(mem_req), 32'd0);
    check_output("mid_reset_busy", 32'(busy), 32'd0);
    check_output("mid_reset_done", 32'(done), 32'd0);
    check_output("mid_reset_rb_write_en", 32'(rb_write_en), 32'd0);
    reset = 1'b0;
    apply_stimulus(tbl[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
